spi_xfer_arbiter: RTL and testbench

- Shares one SPI master (byte-level, active-low tx_en) between NREQ requesters.
- Grants the master round-robin and drives a per-requester active-low chip select, with programmable setup, hold and gap timing.
- Feeds the master one byte at a time and returns each received byte to the granted requester.
- Detects a stuck transfer with a per-byte timeout.

---
 rtl/spi_xfer_arbiter_if.sv | 31 +++
 rtl/spi_xfer_arbiter.sv | 144 ++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_arbiter_if.sv
// spi_xfer_arbiter_if: requester-side and SPI-master-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface spi_xfer_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int LEN_W = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ*8-1:0]     req_data;
    logic [NREQ-1:0]       data_rd;
    logic [7:0]            rx_data;
    logic [NREQ-1:0]       rx_valid;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic [NREQ-1:0]       cs_n;
    logic                  spi_tx_en;
    logic [7:0]            spi_tx_byte;
    logic [7:0]            spi_rx_byte;
    logic                  spi_byte_done;

    modport slave (
        input  req, req_len, req_data, spi_rx_byte, spi_byte_done,
        output data_rd, rx_data, rx_valid, grant, done, err, cs_n, spi_tx_en, spi_tx_byte
    );

    modport master (
        output req, req_len, req_data, spi_rx_byte, spi_byte_done,
        input  data_rd, rx_data, rx_valid, grant, done, err, cs_n, spi_tx_en, spi_tx_byte
    );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one byte-level SPI master between NREQ requesters,
// with chip-select setup/hold/gap timing and a per-byte timeout.
module spi_xfer_arbiter #(
    parameter int NREQ     = 2,
    parameter int LEN_W    = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 1,
    parameter int TIMEOUT  = 1024
) (
    input  logic              sysClk,
    input  logic              reset,
    spi_xfer_arbiter_if.slave bus
);
    localparam int GW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]       r_state, w_nxt;
    logic [GW-1:0]    r_owner, r_rr, w_pick;
    logic [LEN_W-1:0] r_rem;
    logic [15:0]      r_cnt;
    logic [TW-1:0]    r_to;
    logic             r_err_flag;
    logic [NREQ-1:0]  r_grant, r_cs_n, r_data_rd, r_rx_valid, r_done;
    logic             r_err, r_tx_en;
    logic [7:0]       r_tx_byte, r_rx_data;
    logic             w_hit, w_more, w_tout, w_bd, w_fin, w_abort;
    logic [NREQ-1:0]  w_pick_oh, w_own_oh, w_tgt_oh;

    assign bus.grant       = r_grant;
    assign bus.cs_n        = r_cs_n;
    assign bus.data_rd     = r_data_rd;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.spi_tx_en   = r_tx_en;
    assign bus.spi_tx_byte = r_tx_byte;
    assign bus.rx_data     = r_rx_data;

    // Round-robin: the requester closest at-or-after r_rr (wrapping) wins.
    always_comb begin
        int d;
        int best;
        best   = NREQ;
        w_pick = '0;
        for (int j = 0; j < NREQ; j++) begin
            d = (j + NREQ - int'(r_rr)) % NREQ;
            if (bus.req[j] && d < best) begin
                best   = d;
                w_pick = GW'(j);
            end
        end
    end

    assign w_hit     = |bus.req;
    assign w_pick_oh = NREQ'(1) << w_pick;
    assign w_own_oh  = NREQ'(1) << r_owner;
    assign w_tgt_oh  = (r_state == S_IDLE) ? w_pick_oh : w_own_oh;
    assign w_bd      = bus.spi_byte_done;
    assign w_more    = (r_rem != '0) && bus.req[r_owner];
    assign w_tout    = r_to == TW'(TIMEOUT - 1);
    assign w_abort   = (r_state == S_SHIFT) && !w_bd && w_tout;
    assign w_fin     = (w_nxt == S_GAP) && (r_state != S_GAP);

    // SETUP/HOLD last one cycle less than their parameter: the LOAD cycle and
    // the byte_done cycle make up the remainder of the cs_n timing.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hit) w_nxt = (CS_SETUP == 1) ? S_LOAD : S_SETUP;
            S_SETUP: if (r_cnt == 16'(CS_SETUP - 2)) w_nxt = S_LOAD;
            S_LOAD:  w_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_bd && w_more)
                    w_nxt = S_LOAD;
                else if (w_bd || w_tout)
                    w_nxt = (CS_HOLD == 1) ? S_GAP : S_HOLD;
            end
            S_HOLD:  if (r_cnt == 16'(CS_HOLD - 2)) w_nxt = S_GAP;
            S_GAP:   if (r_cnt == 16'(CS_GAP - 1)) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr       <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_to       <= '0;
            r_err_flag <= 1'b0;
            r_grant    <= '0;
            r_cs_n     <= '1;
            r_data_rd  <= '0;
            r_rx_valid <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_tx_en    <= 1'b1;
            r_tx_byte  <= '0;
            r_rx_data  <= '0;
        end else begin
            r_state    <= w_nxt;
            r_cnt      <= (w_nxt != r_state) ? '0 : r_cnt + 16'd1;
            r_to       <= (r_state == S_SHIFT) ? r_to + TW'(1) : '0;
            r_data_rd  <= (w_nxt == S_LOAD) ? w_tgt_oh : '0;
            r_rx_valid <= (r_state == S_SHIFT && w_bd) ? w_own_oh : '0;
            r_done     <= w_fin ? w_own_oh : '0;
            r_err      <= w_fin && (r_err_flag || w_abort);
            if (r_state == S_IDLE && w_hit) begin
                r_owner    <= w_pick;
                r_rem      <= bus.req_len[int'(w_pick) * LEN_W +: LEN_W];
                r_grant    <= w_pick_oh;
                r_cs_n     <= ~w_pick_oh;
                r_err_flag <= 1'b0;
            end
            if (r_state == S_LOAD) begin
                r_tx_byte <= bus.req_data[int'(r_owner) * 8 +: 8];
                r_rem     <= r_rem - 1'b1;
                r_tx_en   <= 1'b0;
            end
            if (r_state == S_SHIFT && w_bd) begin
                r_rx_data <= bus.spi_rx_byte;
                r_tx_en   <= 1'b1;
            end
            if (w_abort) begin
                r_tx_en    <= 1'b1;
                r_err_flag <= 1'b1;
            end
            if (w_fin) begin
                r_grant <= '0;
                r_cs_n  <= '1;
                r_rr    <= (r_owner == GW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: scoreboard bench with a behavioural SPI master and two requesters.
module tb_spi_xfer_arbiter;
    localparam int NREQ = 2, LEN_W = 3, CS_SETUP = 2, CS_HOLD = 2, CS_GAP = 1, TIMEOUT = 16, DLY = 10;

    typedef struct {
        int         r;
        logic [7:0] b;
    } ent_t;

    logic sysClk = 1'b0;
    logic reset  = 1'b0;

    spi_xfer_arbiter_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();

    spi_xfer_arbiter #(
        .NREQ(NREQ), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP),
        .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .sysClk(sysClk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 sysClk = ~sysClk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge sysClk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]      nxt [NREQ] = '{8'h10, 8'h80};
    logic            pend [NREQ] = '{1'b0, 1'b0};
    ent_t            q_tx[$], q_rx[$], e;
    logic [NREQ-1:0] q_gnt[$];
    int              n_rd [NREQ] = '{0, 0};
    int              n_rv [NREQ] = '{0, 0};
    int              n_done = 0, n_err_alone = 0, bad_oh = 0, hi_run = 0, min_gap = 1000;
    int              t_cs = 0, t_en_first = 0, t_en_lo = 0, t_en_hi = 0, t_bd = 0, t_done = 0;
    int              cnt = 0, cur = 0;
    logic            busy = 1'b0, resp_en = 1'b1, first_pending = 1'b0, prev_en = 1'b1;
    logic            err_at_done = 1'b0;
    logic [NREQ-1:0] done_who = '0, prev_cs = '1, prev_gnt = '0;

    // Requester data sources, SPI master model and output monitors.
    always @(negedge sysClk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) nxt[i] = nxt[i] + 8'd1;
            pend[i] = 1'b0;
            bus.req_data[i*8 +: 8] = nxt[i];
        end
        bus.spi_byte_done = 1'b0;
        if (!reset) begin
            busy = 1'b0;
            bus.spi_rx_byte = 8'h00;
            q_tx.delete();
            q_rx.delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.data_rd[i]) begin
                    q_tx.push_back('{i, nxt[i]});
                    pend[i] = 1'b1;
                    n_rd[i]++;
                end
            end
            if (bus.rx_valid != '0) begin
                check("rx_queue", q_rx.size(), 1);
                if (q_rx.size() != 0) begin
                    e = q_rx.pop_front();
                    check("rx_who", bus.rx_valid, 1 << e.r);
                    check("rx_data", bus.rx_data, e.b);
                    n_rv[e.r]++;
                end
            end
            if (bus.cs_n != '1 && prev_cs == '1) begin
                t_cs = cyc;
                first_pending = 1'b1;
            end
            if (!bus.spi_tx_en && prev_en) begin
                t_en_lo = cyc;
                if (first_pending) t_en_first = cyc;
                first_pending = 1'b0;
                check("tx_queue", q_tx.size(), 1);
                if (q_tx.size() != 0) begin
                    e = q_tx.pop_front();
                    check("tx_byte", bus.spi_tx_byte, e.b);
                    cur = e.r;
                    busy = resp_en;
                    cnt = DLY;
                end
            end
            if (bus.spi_tx_en && !prev_en) t_en_hi = cyc;
            if (busy) begin
                if (cnt == 0) begin
                    bus.spi_byte_done = 1'b1;
                    bus.spi_rx_byte = 8'($urandom);
                    q_rx.push_back('{cur, bus.spi_rx_byte});
                    t_bd = cyc;
                    busy = 1'b0;
                end else cnt--;
            end
            if (bus.done != '0) begin
                n_done++;
                t_done = cyc;
                err_at_done = bus.err;
                done_who = bus.done;
            end
            if (bus.err && bus.done == '0) n_err_alone++;
            if (bus.grant != '0 && prev_gnt == '0) q_gnt.push_back(bus.grant);
            if (!$onehot0(bus.grant) || !$onehot0(~bus.cs_n) || !$onehot0(bus.data_rd) ||
                !$onehot0(bus.rx_valid) || !$onehot0(bus.done)) bad_oh++;
            if (bus.cs_n == '1) hi_run++;
            else begin
                if (hi_run != 0 && hi_run < min_gap) min_gap = hi_run;
                hi_run = 0;
            end
        end
        prev_en  = bus.spi_tx_en;
        prev_cs  = bus.cs_n;
        prev_gnt = bus.grant;
    end

    task automatic tick();
        @(negedge sysClk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int base);
        for (int i = 0; i < 2000 && n_done == base; i++) tick();
        check(tag, n_done - base, 1);
    endtask

    int base, rd0, rv0, rd1, rv1;

    initial begin
        bus.req     = '0;
        bus.req_len = '0;
        repeat (3) tick();
        check("rst_grant", bus.grant, 0);
        check("rst_cs_n", bus.cs_n, 2'b11);
        check("rst_tx_en", bus.spi_tx_en, 1);
        check("rst_tx_byte", bus.spi_tx_byte, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_pulses", {bus.data_rd, bus.rx_valid, bus.done, bus.err}, 0);
        reset = 1'b1;
        tick();

        // single requester, three bytes
        base = n_done; rd0 = n_rd[0]; rv0 = n_rv[0];
        bus.req_len = {3'd0, 3'd3};
        bus.req = 2'b01;
        wait_done("t1_done", base);
        bus.req = '0;
        check("t1_setup", t_en_first - t_cs, CS_SETUP);
        check("t1_rd", n_rd[0] - rd0, 3);
        check("t1_rv", n_rv[0] - rv0, 3);
        check("t1_hold", t_done - t_bd, CS_HOLD);
        check("t1_who", done_who, 2'b01);
        check("t1_err", err_at_done, 0);
        repeat (3) tick();

        // round-robin with both requesters held; rr points at 1 after owner 0 finished
        q_gnt.delete();
        min_gap = 1000;
        base = n_done;
        bus.req_len = {3'd1, 3'd1};
        bus.req = 2'b11;
        for (int i = 0; i < 2000 && q_gnt.size() < 4; i++) tick();
        bus.req = '0;
        for (int i = 0; i < 2000 && n_done < base + 4; i++) tick();
        check("rr_done", n_done - base, 4);
        check("rr_count", q_gnt.size(), 4);
        for (int k = 0; k < 4; k++) check("rr_grant", (k < q_gnt.size()) ? q_gnt[k] : 2'b00, 1 << ((1 + k) % 2));
        check("rr_gap", min_gap, CS_GAP + 1);
        repeat (3) tick();

        // truncation: len 5, req dropped while byte 2 is shifting
        base = n_done; rd0 = n_rd[0]; rv0 = n_rv[0];
        bus.req_len = {3'd0, 3'd5};
        bus.req = 2'b01;
        for (int i = 0; i < 2000 && n_rd[0] < rd0 + 2; i++) tick();
        repeat (3) tick();
        bus.req = '0;
        wait_done("tr_done", base);
        check("tr_rd", n_rd[0] - rd0, 2);
        check("tr_rv", n_rv[0] - rv0, 2);
        check("tr_err", err_at_done, 0);
        repeat (3) tick();

        // timeout: master never answers
        resp_en = 1'b0;
        base = n_done; rv0 = n_rv[0];
        bus.req_len = {3'd0, 3'd2};
        bus.req = 2'b01;
        wait_done("to_done", base);
        bus.req = '0;
        check("to_width", t_en_hi - t_en_lo, TIMEOUT);
        check("to_err", err_at_done, 1);
        check("to_who", done_who, 2'b01);
        check("to_rv", n_rv[0] - rv0, 0);
        tick();
        check("to_cs_n", bus.cs_n, 2'b11);
        check("to_tx_en", bus.spi_tx_en, 1);
        resp_en = 1'b1;
        repeat (3) tick();

        // length zero wraps to 2^LEN_W bytes
        base = n_done; rd0 = n_rd[0]; rv0 = n_rv[0];
        bus.req_len = {3'd0, 3'd0};
        bus.req = 2'b01;
        wait_done("wr_done", base);
        bus.req = '0;
        check("wr_rd", n_rd[0] - rd0, 1 << LEN_W);
        check("wr_rv", n_rv[0] - rv0, 1 << LEN_W);
        repeat (3) tick();

        // reset in the middle of a byte
        bus.req_len = {3'd0, 3'd4};
        bus.req = 2'b01;
        for (int i = 0; i < 200 && bus.spi_tx_en; i++) tick();
        check("rs_shift", bus.spi_tx_en, 0);
        repeat (3) tick();
        base = n_done;
        reset = 1'b0;
        tick();
        check("rs_cs_n", bus.cs_n, 2'b11);
        check("rs_tx_en", bus.spi_tx_en, 1);
        check("rs_grant", bus.grant, 0);
        check("rs_done", bus.done, 0);
        bus.req = '0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("rs_no_done", n_done - base, 0);

        // recovery: rr back at 0, only requester 1 asks
        base = n_done; rd1 = n_rd[1]; rv1 = n_rv[1];
        bus.req_len = {3'd2, 3'd0};
        bus.req = 2'b10;
        wait_done("rc_done", base);
        bus.req = '0;
        check("rc_who", done_who, 2'b10);
        check("rc_rd", n_rd[1] - rd1, 2);
        check("rc_rv", n_rv[1] - rv1, 2);
        repeat (3) tick();

        check("rx_left", q_rx.size(), 0);
        check("onehot", bad_oh, 0);
        check("err_alone", n_err_alone, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
